mult_dot_accum: RTL and testbench

Operand sequencer and product accumulator wrapped around the `approx_32x32` multiplier in the MPEG-2 arithmetic datapath. It accepts a vector of unsigned 32-bit operand pairs over a valid/ready stream and feeds one pair per cycle into the multiplier. It tracks the multiplier's one-cycle registered latency and sums the 64-bit products into a wide accumulator. It presents the dot-product result on a valid/ready output, for IDCT/filter stages that need sums of products in precise or approximate mode.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/approx_32x32.sv | 31 +++
 rtl/mult_dot_accum.sv | 96 +++++++++
 tb/tb_mult_dot_accum.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the dot-product accumulator and its multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dot_state_t;

  localparam int MULT_LAT    = 1;
  localparam int PROD_W      = 64;
  localparam int APPROX_DROP = 8;

  // Approximate mode discards the low APPROX_DROP bits of each operand.
  function automatic logic [31:0] approx_operand(input logic [31:0] x);
    return x & ~((32'd1 << APPROX_DROP) - 32'd1);
  endfunction

endpackage

// File: rtl/approx_32x32.sv
// Registered 32x32 unsigned multiplier with a precise and a truncated-operand mode.
module approx_32x32
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              precise_en,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic [PROD_W-1:0] product
);

  logic [31:0]       w_a_op;
  logic [31:0]       w_b_op;
  logic [PROD_W-1:0] r_product;

  assign w_a_op = precise_en ? a : approx_operand(a);
  assign w_b_op = precise_en ? b : approx_operand(b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_product <= '0;
    end else if (clk_en) begin
      r_product <= PROD_W'(w_a_op) * PROD_W'(w_b_op);
    end
  end

  assign product = r_product;

endmodule

// File: rtl/mult_dot_accum.sv
// Streams unsigned operand pairs through approx_32x32 and accumulates the products.
//   state | meaning
//   IDLE  | acc cleared, waiting for start
//   RUN   | accepting operand beats
//   DRAIN | last product in flight
//   DONE  | result offered on out_valid/out_ready
module mult_dot_accum
  import mult_pkg::*;
#(
  parameter int ACC_W = 80,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             precise_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy
);

  dot_state_t        r_state;
  dot_state_t        w_next_state;
  logic [LEN_W-1:0]  r_remain;
  logic              r_precise;
  logic [MULT_LAT-1:0] r_p_vld;
  logic [ACC_W-1:0]  r_acc;
  logic [PROD_W-1:0] w_product;
  logic              w_accept;
  logic              w_start_idle;
  logic              w_handshake;
  logic              w_prod_vld;

  assign in_ready     = (r_state == RUN) && clk_en;
  assign w_accept     = in_valid && in_ready;
  assign w_start_idle = (r_state == IDLE) && start;
  assign out_valid    = (r_state == DONE);
  assign w_handshake  = out_valid && out_ready;
  assign busy         = (r_state != IDLE);
  assign result       = r_acc;
  assign w_prod_vld   = r_p_vld[MULT_LAT-1];

  approx_32x32 u_mult (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .precise_en (r_precise),
    .a          (a),
    .b          (b),
    .product    (w_product)
  );

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = (len == '0) ? DONE : RUN;
      RUN:     if (w_accept && (r_remain == LEN_W'(1))) w_next_state = DRAIN;
      DRAIN:   w_next_state = DONE;
      DONE:    if (w_handshake) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_remain  <= '0;
      r_precise <= 1'b0;
      r_p_vld   <= '0;
      r_acc     <= '0;
    end else if (clk_en) begin
      r_state <= w_next_state;
      // Single-stage multiplier: the valid bit tracks exactly one product.
      r_p_vld <= {MULT_LAT{w_accept}};
      if (w_start_idle) begin
        r_remain  <= len;
        r_precise <= precise_en;
      end else if (w_accept) begin
        r_remain <= r_remain - LEN_W'(1);
      end
      if ((r_state == IDLE) || w_handshake) begin
        r_acc <= '0;
      end else if (w_prod_vld) begin
        r_acc <= r_acc + ACC_W'(w_product);
      end
    end
  end

endmodule

// File: tb/tb_mult_dot_accum.sv
// Randomized self-checking bench for mult_dot_accum against a sum-of-products model.
module tb_mult_dot_accum;

  localparam int ACC_W = 80;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_en;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             precise_en;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a;
  logic [31:0]      b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] pa [64];
  logic [31:0] pb [64];

  mult_dot_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .start      (start),
    .len        (len),
    .precise_en (precise_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain sum of products; approximate mode rounds each operand down to a multiple of 256.
  function automatic logic [ACC_W-1:0] model_sum(input int n, input bit prec);
    logic [ACC_W-1:0] s = '0;
    logic [ACC_W-1:0] x, y;
    for (int i = 0; i < n; i++) begin
      x = ACC_W'(pa[i]);
      y = ACC_W'(pb[i]);
      if (!prec) begin
        x = (x / 256) * 256;
        y = (y / 256) * 256;
      end
      s = s + ((x * y) % (ACC_W'(1) << 64));
    end
    return s;
  endfunction

  // mode bits: 1 toggle in_valid, 2 random stalls/valid, 4 stall cycles 3-4, 8 wiggle precise_en pin
  task automatic run_vec(input int n, input bit prec, input int mode, output logic [ACC_W-1:0] exp);
    int idx = 0;
    int cyc = 0;
    exp = model_sum(n, prec);
    @(negedge clk);
    start = 1'b1; len = LEN_W'(n); precise_en = prec; clk_en = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      in_valid = 1'b1;
      #1;
      chk("len0_out_valid", out_valid, 1);
      chk("len0_result", result, 0);
      chk("len0_in_ready", in_ready, 0);
      in_valid = 1'b0;
      return;
    end
    while (idx < n && cyc < 400) begin
      if (mode & 2) begin
        clk_en   = ($urandom_range(3) != 0);
        in_valid = ($urandom_range(2) != 0);
      end else begin
        clk_en   = (mode & 4) ? !(cyc == 3 || cyc == 4) : 1'b1;
        in_valid = (mode & 1) ? (cyc % 2 == 0) : 1'b1;
      end
      a = pa[idx];
      b = pb[idx];
      if (mode & 8) precise_en = 1'($urandom_range(1));
      #1;
      if (!clk_en) chk("stall_in_ready", in_ready, 0);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    chk("beats_consumed", idx, n);
    in_valid = 1'b1;
    clk_en   = 1'b1;
    #1;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("done_out_valid", out_valid, 1);
    chk("done_result", result, exp);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_busy", busy, 0);
    chk("post_hs_result", result, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [ACC_W-1:0] exp;
    int n;
    rst = 1'b0; clk_en = 1'b1; start = 1'b0; len = '0; precise_en = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back precise vector.
    pa[0] = 32'd3;          pb[0] = 32'd5;
    pa[1] = 32'd7;          pb[1] = 32'd11;
    pa[2] = 32'hFFFFFFFF;   pb[2] = 32'hFFFFFFFF;
    run_vec(3, 1'b1, 0, exp);
    chk("t1_literal", result, 80'hFFFFFFFE0000005D);
    handshake();

    // Zero-length vector.
    run_vec(0, 1'b1, 0, exp);
    handshake();

    // Toggling valid with a two-cycle stall mid-vector.
    for (int i = 0; i < 4; i++) begin
      pa[i] = 32'(2 * i + 1);
      pb[i] = 32'(2 * i + 2);
    end
    run_vec(4, 1'b1, 1 | 4, exp);
    chk("t3_literal", result, 80'd100);
    handshake();

    // Approximate mode, 16 random pairs, precise_en pin wiggling.
    for (int i = 0; i < 16; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    run_vec(16, 1'b0, 8, exp);
    handshake();

    // Hold in DONE with out_ready low; a start there must be ignored.
    for (int i = 0; i < 5; i++) begin
      pa[i] = $urandom;
      pb[i] = $urandom;
    end
    run_vec(5, 1'b1, 0, exp);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      len   = 8'd3;
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, exp);
    end
    start = 1'b0;
    handshake();
    @(negedge clk);
    #1;
    chk("ignored_start_busy", busy, 0);

    // Random vectors with random stalls and valid gaps.
    for (int v = 0; v < 4; v++) begin
      n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++) begin
        pa[i] = (v == 0) ? 32'hFFFFFFFF : $urandom;
        pb[i] = (v == 0) ? 32'hFFFFFFFF : $urandom;
      end
      run_vec(n, 1'($urandom_range(1)), 2 | 8, exp);
      handshake();
    end

    // Asynchronous reset after 2 of 4 beats.
    @(negedge clk);
    start = 1'b1; len = 8'd4; precise_en = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a = 32'd9; b = 32'd9;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_result", result, 0);
    @(negedge clk);
    rst = 1'b1;
    pa[0] = 32'd2; pb[0] = 32'd2;
    run_vec(1, 1'b1, 0, exp);
    chk("after_rst_literal", result, 80'd4);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
